// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl
// Purpose  : MEM-stage sequencer running a req/ack data-memory transaction and
//            stalling/bubbling the pipeline until it completes.
// Revision : 1.0
// ============================================================================
module mem_stage_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadIn,
  input  logic              MemWriteIn,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic [DATA_W-1:0] wdataIn,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              wb_bubble,
  output logic [DATA_W-1:0] dataMemoryDataOut,
  output logic              mem_err
);

  localparam int              TMR_W   = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [TMR_W-1:0]   timer_inc;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               op_req;

  // Gated by rst so the combinational stall is also 0 while reset is held.
  assign op_req = rst & (MemReadIn | MemWriteIn);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    timer_inc = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;
    mem_req   = 1'b0;
    mem_err   = 1'b0;
    stall     = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall   = op_req;
        timer_d = '0;
        if (op_req) begin
          we_d    = MemWriteIn;
          addr_d  = addrIn;
          wdata_d = wdataIn;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        // A late ack wins over a timeout expiring in the same cycle.
        if (mem_ack) begin
          if (!we_q) rdata_d = mem_rdata;
          timer_d = '0;
          state_d = S_DONE;
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TMR_MAX) state_d = S_ERR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        stall   = 1'b1;
        mem_err = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wb_bubble         = stall;
  assign mem_we            = we_q;
  assign mem_addr          = addr_q;
  assign mem_wdata         = wdata_q;
  assign dataMemoryDataOut = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Purpose  : Directed self-checking bench for mem_stage_ctrl with a
//            transaction-level reference model compared every cycle.
// Revision : 1.0
// ============================================================================
module tb_mem_stage_ctrl;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          MemReadIn = 1'b0, MemWriteIn = 1'b0;
  logic [AW-1:0] addrIn = '0;
  logic [DW-1:0] wdataIn = '0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_req, mem_we, stall, wb_bubble, mem_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, dataMemoryDataOut;

  int n_chk  = 0;
  int n_fail = 0;

  mem_stage_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
    .addrIn(addrIn), .wdataIn(wdataIn), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .stall(stall), .wb_bubble(wb_bubble),
    .dataMemoryDataOut(dataMemoryDataOut), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: is a transfer in flight, how long has it waited,
  // is this the single release cycle after it, has it failed.
  logic          m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_data = '0;
  int            m_wait = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_we <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_data <= '0; m_wait <= 0;
    end else if (m_err) begin
      m_err <= 1'b1;
    end else if (m_busy) begin
      m_wait <= m_wait + 1;
      if (mem_ack) begin
        if (!m_we) m_data <= mem_rdata;
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end else if (m_wait + 1 >= TO) begin
        m_busy <= 1'b0;
        m_err  <= 1'b1;
      end
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (MemReadIn || MemWriteIn) begin
      m_busy  <= 1'b1;
      m_wait  <= 0;
      m_we    <= MemWriteIn;
      m_addr  <= addrIn;
      m_wdata <= wdataIn;
    end
  end

  always @(negedge clk) begin
    logic e_stall;
    e_stall = m_busy || m_err ||
              (!m_done && rst && (MemReadIn || MemWriteIn));
    chk("cyc_req",    {31'd0, mem_req},   {31'd0, m_busy});
    chk("cyc_err",    {31'd0, mem_err},   {31'd0, m_err});
    chk("cyc_stall",  {31'd0, stall},     {31'd0, e_stall});
    chk("cyc_bubble", {31'd0, wb_bubble}, {31'd0, e_stall});
    chk("cyc_rdata",  dataMemoryDataOut,  m_data);
    if (m_busy) begin
      chk("cyc_we",    {31'd0, mem_we}, {31'd0, m_we});
      chk("cyc_addr",  mem_addr,        m_addr);
      chk("cyc_wdata", mem_wdata,       m_wdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One memory op: IDLE cycle, ackw ACCESS cycles (ack in the last), DONE cycle.
  task automatic run_op(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input int ackw, input logic [31:0] rd,
                        input logic nxt, input logic [31:0] nxt_a,
                        output int st_cnt, output int rq_cnt);
    st_cnt = 0;
    rq_cnt = 0;
    step();
    MemReadIn = !wr; MemWriteIn = wr; addrIn = a; wdataIn = wd; mem_ack = 1'b0;
    @(negedge clk);
    st_cnt += int'(stall); rq_cnt += int'(mem_req);
    for (int k = 1; k <= ackw; k++) begin
      step();
      mem_ack   = (k == ackw);
      mem_rdata = (k == ackw) ? rd : 32'hFFFF_FFFF;
      @(negedge clk);
      st_cnt += int'(stall); rq_cnt += int'(mem_req);
    end
    step();
    mem_ack = 1'b0;
    if (nxt) begin
      MemReadIn = 1'b1; MemWriteIn = 1'b0; addrIn = nxt_a;
    end else begin
      MemReadIn = 1'b0; MemWriteIn = 1'b0;
    end
    @(negedge clk);
    st_cnt += int'(stall); rq_cnt += int'(mem_req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, r;
    #2;
    chk("rst_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall},   32'd0);
    chk("rst_err",   {31'd0, mem_err}, 32'd0);
    chk("rst_data",  dataMemoryDataOut, 32'd0);
    #10 rst = 1'b1;

    run_op(1'b0, 32'h10, 32'h0, 1, 32'h2, 1'b0, 32'h0, s, r);
    chk("load0_stall_cycles", s, 32'd2);
    chk("load0_req_cycles",   r, 32'd1);
    chk("load0_addr",         mem_addr, 32'h10);
    chk("load0_we",           {31'd0, mem_we}, 32'd0);
    chk("load0_data",         dataMemoryDataOut, 32'h2);

    run_op(1'b1, 32'h20, 32'h3, 3, 32'h77, 1'b0, 32'h0, s, r);
    chk("store_stall_cycles", s, 32'd4);
    chk("store_req_cycles",   r, 32'd3);
    chk("store_we",           {31'd0, mem_we}, 32'd1);
    chk("store_wdata",        mem_wdata, 32'h3);
    chk("store_data_kept",    dataMemoryDataOut, 32'h2);

    run_op(1'b0, 32'h30, 32'h0, 2, 32'hA1, 1'b1, 32'h34, s, r);
    chk("b2b_first_stall",  s, 32'd3);
    chk("b2b_done_stall",   {31'd0, stall}, 32'd0);
    chk("b2b_first_data",   dataMemoryDataOut, 32'hA1);
    run_op(1'b0, 32'h34, 32'h0, 1, 32'hB2, 1'b0, 32'h0, s, r);
    chk("b2b_second_stall", s, 32'd2);
    chk("b2b_second_data",  dataMemoryDataOut, 32'hB2);

    run_op(1'b0, 32'h50, 32'h0, TO, 32'hC3, 1'b0, 32'h0, s, r);
    chk("edge_ack_stall", s, TO + 1);
    chk("edge_ack_req",   r, TO);
    chk("edge_ack_err",   {31'd0, mem_err}, 32'd0);
    chk("edge_ack_data",  dataMemoryDataOut, 32'hC3);

    step();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD;
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("spurious_data",  dataMemoryDataOut, 32'hC3);
    chk("spurious_stall", {31'd0, stall}, 32'd0);

    step();
    MemReadIn = 1'b1; addrIn = 32'h60;
    step();
    @(negedge clk);
    chk("midrst_req_before", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_req",    {31'd0, mem_req},   32'd0);
    chk("midrst_stall",  {31'd0, stall},     32'd0);
    chk("midrst_bubble", {31'd0, wb_bubble}, 32'd0);
    chk("midrst_err",    {31'd0, mem_err},   32'd0);
    chk("midrst_data",   dataMemoryDataOut,  32'd0);
    @(negedge clk);
    #2 MemReadIn = 1'b0;
    rst = 1'b1;

    step();
    MemReadIn = 1'b1; addrIn = 32'h70;
    r = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      r += int'(mem_req);
      step();
    end
    chk("timeout_req_cycles", r, TO);
    chk("timeout_err",   {31'd0, mem_err}, 32'd1);
    chk("timeout_stall", {31'd0, stall},   32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hBAD;
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("err_ack_err",  {31'd0, mem_err}, 32'd1);
    chk("err_ack_data", dataMemoryDataOut, 32'd0);
    #2 rst = 1'b0;
    MemReadIn = 1'b0;
    #1;
    chk("err_cleared", {31'd0, mem_err}, 32'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
